// File: rtl/bf_pkg.sv
// Shared types and constants for the beamformer weight SPI loader.
package bf_pkg;

    localparam int N_CH   = 8;
    localparam int W_BITS = 5;

    typedef enum logic [1:0] {
        CMD_WRITE  = 2'b00,
        CMD_COMMIT = 2'b01,
        CMD_CLEAR  = 2'b10,
        CMD_NOP    = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        SEL_COS_1 = 2'b00,
        SEL_SIN_1 = 2'b01,
        SEL_COS_2 = 2'b10,
        SEL_SIN_2 = 2'b11
    } sel_e;

    // 16-bit word layout: cmd | channel | select | reserved/parity | value
    localparam int WORD_BITS = 16;
    localparam int CMD_MSB   = 15;
    localparam int CMD_LSB   = 14;
    localparam int CH_MSB    = 13;
    localparam int CH_LSB    = 11;
    localparam int SEL_MSB   = 10;
    localparam int SEL_LSB   = 9;
    localparam int PAR_BIT   = 8;
    localparam int VAL_MSB   = 4;
    localparam int VAL_LSB   = 0;

    localparam logic signed [W_BITS-1:0] WT_COS_RST = 5'sd15;
    localparam logic signed [W_BITS-1:0] WT_SIN_RST = 5'sd0;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_WAIT_HI = 2'd0;
    localparam fsm_state_t ST_IDLE    = 2'd1;
    localparam fsm_state_t ST_SHIFT   = 2'd2;

    // Sine selects sit on odd codes; they reset to zero, cosines to full scale.
    function automatic logic is_sin_sel(input logic [1:0] sel);
        return sel[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer plus an edge-detect flop, giving clean rise/fall pulses
// in the system clock domain. RST_VAL sets the level all three flops reset to.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/bf_weight_spi.sv
// SPI mode-0 slave loading beamformer weights into a shadow bank that is committed
// atomically to the active outputs. Optional even-parity check: BF_WSPI_PARITY_EN.
module bf_weight_spi #(
    parameter int N_CH     = bf_pkg::N_CH,
    parameter int W_BITS   = bf_pkg::W_BITS,
    parameter int ERR_BITS = 8
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           sclk,
    input  logic                           ss,
    input  logic                           mosi,
    output logic [N_CH-1:0][W_BITS-1:0]    w_cos_1,
    output logic [N_CH-1:0][W_BITS-1:0]    w_sin_1,
    output logic [N_CH-1:0][W_BITS-1:0]    w_cos_2,
    output logic [N_CH-1:0][W_BITS-1:0]    w_sin_2,
    output logic                           wt_update,
    output logic [ERR_BITS-1:0]            frame_err_cnt
);
    import bf_pkg::*;

    typedef logic [3:0][N_CH-1:0][W_BITS-1:0] bank_t;

    function automatic bank_t rst_bank();
        bank_t b;
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < N_CH; c++) begin
                b[s][c] = is_sin_sel(2'(s)) ? W_BITS'(WT_SIN_RST) : W_BITS'(WT_COS_RST);
            end
        end
        return b;
    endfunction

    function automatic logic [ERR_BITS-1:0] sat_add(input logic [ERR_BITS-1:0] a,
                                                    input logic [1:0]          inc);
        logic [ERR_BITS:0] s;
        s = {1'b0, a} + (ERR_BITS+1)'(inc);
        return s[ERR_BITS] ? '1 : s[ERR_BITS-1:0];
    endfunction

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_ss_sync, w_ss_rise, w_ss_fall;
    logic r_mosi_meta, r_mosi_sync;

    spi_sync_edge #(.RST_VAL(1'b0)) u_sclk_sync (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_async (sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.RST_VAL(1'b1)) u_ss_sync (
        .i_clk   (clock),
        .i_rst   (reset),
        .i_async (ss),
        .o_sync  (w_ss_sync),
        .o_rise  (w_ss_rise),
        .o_fall  (w_ss_fall)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // ---- Frame FSM and shifter ----
    fsm_state_t  r_state;
    logic [1:0]  r_flush;
    logic [3:0]  r_bitcnt;
    logic [14:0] r_shift;
    logic [15:0] r_word;
    logic        r_word_done;
    logic [3:0]  w_bitcnt_nxt;
    logic        w_frame_err;

    // A simultaneous sclk rise is counted before the ss-rise completeness check.
    always_comb begin
        w_bitcnt_nxt = r_bitcnt + 4'(w_sclk_rise);
        w_frame_err  = (r_state == ST_SHIFT) && w_ss_rise && (w_bitcnt_nxt != 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_WAIT_HI;
            r_flush     <= 2'd0;
            r_bitcnt    <= 4'd0;
            r_shift     <= '0;
            r_word      <= '0;
            r_word_done <= 1'b0;
        end else begin
            r_word_done <= 1'b0;
            case (r_state)
                // The ss synchronizer comes out of reset reading high; let it
                // flush before trusting that ss is really deasserted.
                ST_WAIT_HI: begin
                    if (r_flush != 2'd3) begin
                        r_flush <= r_flush + 2'd1;
                    end else if (w_ss_sync) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_IDLE: begin
                    if (w_ss_fall) begin
                        r_bitcnt <= 4'd0;
                        r_state  <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_sclk_rise) begin
                        r_shift  <= {r_shift[13:0], r_mosi_sync};
                        r_bitcnt <= w_bitcnt_nxt;
                        if (r_bitcnt == 4'd15) begin
                            r_word      <= {r_shift, r_mosi_sync};
                            r_word_done <= 1'b1;
                        end
                    end
                    if (w_ss_rise) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_WAIT_HI;
            endcase
        end
    end

    // ---- Word decode, banks and error counter ----
    cmd_e              w_cmd;
    logic [2:0]        w_ch;
    logic [1:0]        w_sel;
    logic [W_BITS-1:0] w_val;
    logic              w_par_ok;
    logic              w_accept;
    logic              w_par_err;
    logic [1:0]        w_err_inc;

    assign w_cmd = cmd_e'(r_word[CMD_MSB:CMD_LSB]);
    assign w_ch  = r_word[CH_MSB:CH_LSB];
    assign w_sel = r_word[SEL_MSB:SEL_LSB];
    assign w_val = W_BITS'(r_word[VAL_MSB:VAL_LSB]);

`ifdef BF_WSPI_PARITY_EN
    assign w_par_ok = ~^r_word;
`else
    assign w_par_ok = 1'b1;
`endif

    assign w_accept  = r_word_done & w_par_ok;
    assign w_par_err = r_word_done & ~w_par_ok;
    assign w_err_inc = {1'b0, w_frame_err} + {1'b0, w_par_err};

    bank_t                r_shadow;
    bank_t                r_active;
    logic                 r_wt_update;
    logic [ERR_BITS-1:0]  r_err_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow    <= rst_bank();
            r_active    <= rst_bank();
            r_wt_update <= 1'b0;
            r_err_cnt   <= '0;
        end else begin
            r_wt_update <= 1'b0;
            r_err_cnt   <= sat_add(r_err_cnt, w_err_inc);
            if (w_accept) begin
                case (w_cmd)
                    CMD_WRITE:  r_shadow[w_sel][w_ch] <= w_val;
                    CMD_COMMIT: begin
                        r_active    <= r_shadow;
                        r_wt_update <= 1'b1;
                    end
                    CMD_CLEAR:  r_shadow <= rst_bank();
                    default:    ;
                endcase
            end
        end
    end

    assign w_cos_1       = r_active[SEL_COS_1];
    assign w_sin_1       = r_active[SEL_SIN_1];
    assign w_cos_2       = r_active[SEL_COS_2];
    assign w_sin_2       = r_active[SEL_SIN_2];
    assign wt_update     = r_wt_update;
    assign frame_err_cnt = r_err_cnt;

    logic w_unused;
    assign w_unused = ^{w_sclk_sync, w_sclk_fall, r_word[PAR_BIT:VAL_MSB+1]};

endmodule

// File: tb/tb_bf_weight_spi.sv
// Bench for bf_weight_spi: directed SPI frames, a word-level model of the weight
// banks and error counter, and a per-cycle comparison of every output.
module tb_bf_weight_spi;

    localparam int NC   = 8;
    localparam int WB   = 5;
    localparam int EB   = 8;
    localparam int HALF = 4;
    localparam int EMAX = (1 << EB) - 1;

`ifdef BF_WSPI_PARITY_EN
    localparam logic [15:0] W_WR = 16'h1F1A;
    localparam logic [15:0] W_CM = 16'h4100;
    localparam logic [15:0] W_CL = 16'h8100;
    localparam bit          PAR  = 1'b1;
`else
    localparam logic [15:0] W_WR = 16'h1E1A;
    localparam logic [15:0] W_CM = 16'h4000;
    localparam logic [15:0] W_CL = 16'h8000;
    localparam bit          PAR  = 1'b0;
`endif

    logic clock = 1'b0;
    logic reset, sclk, ss, mosi;
    logic [NC-1:0][WB-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
    logic                  wt_update;
    logic [EB-1:0]         frame_err_cnt;

    bf_weight_spi #(.N_CH(NC), .W_BITS(WB), .ERR_BITS(EB)) dut (
        .clock         (clock),
        .reset         (reset),
        .sclk          (sclk),
        .ss            (ss),
        .mosi          (mosi),
        .w_cos_1       (w_cos_1),
        .w_sin_1       (w_sin_1),
        .w_cos_2       (w_cos_2),
        .w_sin_2       (w_sin_2),
        .wt_update     (wt_update),
        .frame_err_cnt (frame_err_cnt)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit chk_en = 1'b0;

    always @(posedge clock) cyc <= cyc + 1;

    // ---- model state ----
    int         m_shadow [4][NC];
    int         m_active [4][NC];
    int         m_err;
    bit         m_seen_high;
    bit         m_in_frame;
    int         m_bits;
    logic [15:0] m_sr;

    typedef struct {
        int          due;
        bit          is_word;
        logic [15:0] word;
    } ev_t;
    ev_t evq[$];

    function automatic void model_reset();
        for (int s = 0; s < 4; s++)
            for (int c = 0; c < NC; c++) begin
                m_shadow[s][c] = (s % 2 == 0) ? 15 : 0;
                m_active[s][c] = (s % 2 == 0) ? 15 : 0;
            end
        m_err       = 0;
        m_in_frame  = 1'b0;
        m_seen_high = (ss == 1'b1);
        m_bits      = 0;
        m_sr        = '0;
        evq.delete();
    endfunction

    function automatic bit apply_ev(input ev_t e);
        int w, cmd, ch, sel, val;
        if (!e.is_word || (PAR && ($countones(e.word) % 2 != 0))) begin
            m_err = (m_err < EMAX) ? m_err + 1 : EMAX;
            return 1'b0;
        end
        w   = int'(e.word);
        cmd = w / 16384;
        ch  = (w / 2048) % 8;
        sel = (w / 512) % 4;
        val = w % 32;
        if (cmd == 0) m_shadow[sel][ch] = val;
        if (cmd == 2)
            for (int s = 0; s < 4; s++)
                for (int c = 0; c < NC; c++)
                    m_shadow[s][c] = (s % 2 == 0) ? 15 : 0;
        if (cmd == 1) begin
            m_active = m_shadow;
            return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NC*WB-1:0] pack(input int s);
        logic [NC*WB-1:0] p;
        for (int c = 0; c < NC; c++) p[c*WB +: WB] = WB'(m_active[s][c]);
        return p;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // ---- per-cycle compare ----
    always @(negedge clock) begin
        bit   exp_upd;
        ev_t  e;
        if (chk_en) begin
            exp_upd = 1'b0;
            while (evq.size() > 0 && evq[0].due <= cyc) begin
                e = evq.pop_front();
                if (apply_ev(e)) exp_upd = 1'b1;
            end
            chk("cyc_cos1", 64'(w_cos_1), 64'(pack(0)));
            chk("cyc_sin1", 64'(w_sin_1), 64'(pack(1)));
            chk("cyc_cos2", 64'(w_cos_2), 64'(pack(2)));
            chk("cyc_sin2", 64'(w_sin_2), 64'(pack(3)));
            chk("cyc_upd",  64'(wt_update), 64'(exp_upd));
            chk("cyc_err",  64'(frame_err_cnt), 64'(m_err));
        end
    end

    // ---- stimulus helpers ----
    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_ss(input logic v);
        if (v && !ss) begin
            if (m_in_frame && (m_bits % 16 != 0))
                evq.push_back('{due: cyc + 3, is_word: 1'b0, word: 16'h0});
            m_in_frame  = 1'b0;
            m_seen_high = 1'b1;
        end else if (!v && ss && m_seen_high) begin
            m_in_frame = 1'b1;
            m_bits     = 0;
        end
        ss = v;
        tick(HALF);
    endtask

    task automatic send_bit(input logic b);
        mosi = b;
        tick(HALF);
        sclk = 1'b1;
        if (m_in_frame) begin
            m_sr = {m_sr[14:0], b};
            m_bits++;
            if (m_bits % 16 == 0)
                evq.push_back('{due: cyc + 4, is_word: 1'b1, word: m_sr});
        end
        tick(HALF);
        sclk = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        for (int i = 15; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic wait_upd(input string nm);
        int n;
        n = 0;
        while (wt_update !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        chk(nm, 64'(wt_update), 64'(1));
    endtask

    initial begin
        #1_500_000;
        $display("FAIL timeout cycle=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        sclk  = 1'b0;
        ss    = 1'b1;
        mosi  = 1'b0;
        model_reset();
        tick(3);
        chk_en = 1'b1;
        reset  = 1'b0;
        tick(10);

        // reset values
        chk("rst_cos1", 64'(w_cos_1), 64'({8{5'd15}}));
        chk("rst_sin1", 64'(w_sin_1), 64'(0));
        chk("rst_cos2", 64'(w_cos_2), 64'({8{5'd15}}));
        chk("rst_sin2", 64'(w_sin_2), 64'(0));
        chk("rst_upd",  64'(wt_update), 64'(0));
        chk("rst_err",  64'(frame_err_cnt), 64'(0));

        // write then commit
        set_ss(1'b0);
        send_word(W_WR);
        tick(6);
        chk("pre_commit_sin2", 64'(w_sin_2), 64'(0));
        send_word(W_CM);
        wait_upd("commit_pulse");
        chk("commit_sin2_3", 64'(w_sin_2[3]), 64'(5'h1A));
        chk("commit_sin2",   64'(w_sin_2), 64'(40'h00_000D_0000));
        chk("commit_cos1",   64'(w_cos_1), 64'({8{5'd15}}));
        set_ss(1'b1);
        tick(4);

        // write, clear, commit
        set_ss(1'b0);
        send_word(W_WR);
        send_word(W_CL);
        send_word(W_CM);
        wait_upd("clear_commit_pulse");
        chk("clear_sin2", 64'(w_sin_2), 64'(0));
        set_ss(1'b1);
        tick(4);

        // partial frames
        for (int f = 0; f < 300; f++) begin
            set_ss(1'b0);
            for (int b = 0; b < 9; b++) send_bit(1'b1);
            set_ss(1'b1);
            tick(4);
            if (f == 0) chk("err_one", 64'(frame_err_cnt), 64'(1));
        end
        chk("err_sat", 64'(frame_err_cnt), 64'(255));
        chk("partial_sin2", 64'(w_sin_2), 64'(0));

        // reset in the middle of a frame
        set_ss(1'b0);
        for (int b = 0; b < 8; b++) send_bit(1'b0);
        chk_en = 1'b0;
        reset  = 1'b1;
        model_reset();
        tick(1);
        chk_en = 1'b1;
        tick(2);
        reset = 1'b0;
        send_word(W_WR);
        send_word(W_CM);
        tick(6);
        chk("midrst_sin2", 64'(w_sin_2), 64'(0));
        chk("midrst_err",  64'(frame_err_cnt), 64'(0));
        set_ss(1'b1);
        tick(4);
        set_ss(1'b0);
        send_word(W_WR);
        send_word(W_CM);
        wait_upd("rearm_pulse");
        chk("rearm_sin2_3", 64'(w_sin_2[3]), 64'(5'h1A));
        set_ss(1'b1);
        tick(4);

`ifdef BF_WSPI_PARITY_EN
        set_ss(1'b0);
        send_word(W_CL);
        send_word(W_CM);
        set_ss(1'b1);
        tick(8);
        chk("par_cleared", 64'(w_sin_2), 64'(0));
        set_ss(1'b0);
        send_word(16'h1E1A);
        set_ss(1'b1);
        tick(8);
        chk("par_bad_err", 64'(frame_err_cnt), 64'(1));
        set_ss(1'b0);
        send_word(W_CM);
        set_ss(1'b1);
        tick(8);
        chk("par_bad_dropped", 64'(w_sin_2), 64'(0));
        set_ss(1'b0);
        send_word(16'h1F1A);
        send_word(W_CM);
        set_ss(1'b1);
        tick(8);
        chk("par_good_sin2_3", 64'(w_sin_2[3]), 64'(5'h1A));
`endif

        tick(10);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
